// File: rtl/param_reg_bank.sv
// Byte-addressed parameter register bank: control bytes, command pulses,
// sticky event bits with masked interrupt, status snapshot and device ID.
module param_reg_bank #(
  parameter int                    ADDR_W       = 5,
  parameter int                    NUM_CTRL     = 2,
  parameter logic [8*NUM_CTRL-1:0] CTRL_RESET   = '0,
  parameter int                    STATUS_BYTES = 12,
  parameter logic [7:0]            DEVICE_ID    = 8'hB9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      wr_en,
  input  logic [7:0]                wr_data,
  input  logic                      rd_en,
  output logic [7:0]                rd_data,
  output logic [8*NUM_CTRL-1:0]     ctrl_out,
  output logic [7:0]                cmd_pulse,
  input  logic [7:0]                event_in,
  input  logic [8*STATUS_BYTES-1:0] status_in,
  output logic                      irq
);

  localparam int SNAP_BASE = NUM_CTRL + 3;

  localparam logic [ADDR_W-1:0] CMD_A    = ADDR_W'(NUM_CTRL);
  localparam logic [ADDR_W-1:0] STICKY_A = ADDR_W'(NUM_CTRL + 1);
  localparam logic [ADDR_W-1:0] MASK_A   = ADDR_W'(NUM_CTRL + 2);
  localparam logic [ADDR_W-1:0] SNAP_A   = ADDR_W'(SNAP_BASE);
  localparam logic [ADDR_W-1:0] ID_A     = '1;

  if (NUM_CTRL + 3 + STATUS_BYTES > (1 << ADDR_W) - 1) begin : g_bad_map
    $error("param_reg_bank: address map does not fit below the ID address");
  end
  if (STATUS_BYTES < 2) begin : g_bad_status
    $error("param_reg_bank: STATUS_BYTES must be at least 2");
  end

  logic [8*NUM_CTRL-1:0]         ctrl_q;
  logic [7:0]                    sticky_q;
  logic [7:0]                    mask_q;
  // Byte 0 is always read live, so only bytes 1.. are held in the shadow.
  logic [8*(STATUS_BYTES-1)-1:0] shadow_q;
  logic [7:0]                    rd_mux;
  logic [7:0]                    sticky_clr;

  assign ctrl_out   = ctrl_q;
  assign sticky_clr = (wr_en && addr == STICKY_A) ? wr_data : 8'h00;

  always_comb begin
    rd_mux = 8'h00;
    for (int k = 0; k < NUM_CTRL; k++)
      if (addr == ADDR_W'(k)) rd_mux = ctrl_q[8*k +: 8];
    if (addr == STICKY_A) rd_mux = sticky_q;
    if (addr == MASK_A)   rd_mux = mask_q;
    if (addr == SNAP_A)   rd_mux = status_in[7:0];
    for (int k = 1; k < STATUS_BYTES; k++)
      if (addr == ADDR_W'(SNAP_BASE + k)) rd_mux = shadow_q[8*(k-1) +: 8];
    if (addr == ID_A)     rd_mux = DEVICE_ID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RESET;
      sticky_q  <= 8'h00;
      mask_q    <= 8'h00;
      shadow_q  <= '0;
      cmd_pulse <= 8'h00;
      irq       <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++)
        if (wr_en && addr == ADDR_W'(k)) ctrl_q[8*k +: 8] <= wr_data;
      if (wr_en && addr == MASK_A) mask_q <= wr_data;
      cmd_pulse <= (wr_en && addr == CMD_A) ? wr_data : 8'h00;
      // Event set is OR-ed in after the clear so a coincident set wins.
      sticky_q  <= (sticky_q & ~sticky_clr) | event_in;
      irq       <= |(sticky_q & mask_q);
      if (rd_en) begin
        rd_data <= rd_mux;
        if (addr == SNAP_A) shadow_q <= status_in[8*STATUS_BYTES-1:8];
      end
    end
  end

endmodule
